// File: rtl/cpu_pkg.sv
// Shared CPU-family definitions: default address width, BTB entry layout and
// direction-counter reset/allocate values.
package cpu_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 16;
    localparam int unsigned DEFAULT_IDX_W  = 4;
    localparam int unsigned DEFAULT_CTR_W  = 2;

    // Entry layout for the default BTB geometry.
    typedef struct packed {
        logic                                     valid;
        logic [DEFAULT_ADDR_W-DEFAULT_IDX_W-1:0]  tag;
        logic [DEFAULT_ADDR_W-1:0]                target;
        logic [DEFAULT_CTR_W-1:0]                 ctr;
    } btb_entry_t;

    function automatic int unsigned ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and EX-side resolve/train signals of the BTB.
interface branch_predictor_btb_if #(
    parameter int unsigned ADDR_W = cpu_pkg::DEFAULT_ADDR_W
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              inv;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [15:0]       mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, inv,
        input  pred_taken, pred_target, mispredict, redirect_pc, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, inv,
        output pred_taken, pred_target, mispredict, redirect_pc, mispred_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter next-value logic; holds at 0 and all-ones.
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (inc && !dec && (cnt != {W{1'b1}})) begin
            cnt_next = cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt_next = cnt - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters: combinational
// lookup in IF, training and mispredict detection in EX.
module branch_predictor_btb
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2
) (
    input logic                   clk,
    input logic                   pc_reset_n,
    branch_predictor_btb_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    entry_t      table_q [ENTRIES];
    logic [15:0] mispred_cnt_q;

    // Lookup
    logic [IDX_W-1:0] lk_idx;
    entry_t           lk_entry;
    logic             lk_hit;

    always_comb begin
        lk_idx          = bus.if_pc[IDX_W-1:0];
        lk_entry        = table_q[lk_idx];
        lk_hit          = lk_entry.valid && (lk_entry.tag == bus.if_pc[ADDR_W-1:IDX_W]);
        bus.pred_taken  = lk_hit && lk_entry.ctr[CTR_W-1];
        bus.pred_target = bus.pred_taken ? lk_entry.target : bus.if_pc + ADDR_W'(1);
    end

    // Resolve
    always_comb begin
        bus.mispredict  = bus.ex_valid &&
                          ((bus.ex_pred_taken != bus.ex_taken) ||
                           (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
        bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(1);
        bus.mispred_cnt = mispred_cnt_q;
    end

    // Train
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    entry_t           up_entry;
    logic             up_hit;
    logic [CTR_W-1:0] up_ctr_next;

    always_comb begin
        up_idx   = bus.ex_pc[IDX_W-1:0];
        up_tag   = bus.ex_pc[ADDR_W-1:IDX_W];
        up_entry = table_q[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == up_tag);
    end

    sat_counter #(
        .W (CTR_W)
    ) u_dir_ctr (
        .cnt      (up_entry.ctr),
        .inc      (bus.ex_taken),
        .dec      (!bus.ex_taken),
        .cnt_next (up_ctr_next)
    );

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (bus.inv) begin
            // Invalidate only; counters and targets survive for re-allocation.
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (bus.ex_valid) begin
            if (up_hit) begin
                table_q[up_idx].ctr <= up_ctr_next;
                if (bus.ex_taken) begin
                    table_q[up_idx].target <= bus.ex_target;
                end
            end else if (bus.ex_taken) begin
                table_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: bus.ex_target,
                                     ctr: CTR_WT};
            end
        end
    end

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            mispred_cnt_q <= '0;
        end else if (bus.mispredict && (mispred_cnt_q != 16'hFFFF)) begin
            mispred_cnt_q <= mispred_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomised and directed bench for branch_predictor_btb against a table-level model.
module tb_branch_predictor_btb;

    logic clk = 1'b0;
    logic pc_reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_btb_if #(.ADDR_W(16)) bus ();

    branch_predictor_btb #(
        .ADDR_W  (16),
        .ENTRIES (16),
        .CTR_W   (2)
    ) dut (
        .clk        (clk),
        .pc_reset_n (pc_reset_n),
        .bus        (bus)
    );

    // Model: 16 entries, plain integers
    bit m_valid [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_ctr   [16];
    int m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_cnt = 0;
    endfunction

    function automatic bit m_hit(input int pc);
        return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
    endfunction

    function automatic bit exp_taken(input int pc);
        return m_hit(pc) && (m_ctr[pc % 16] >= 2);
    endfunction

    function automatic int exp_target(input int pc);
        return exp_taken(pc) ? m_tgt[pc % 16] : (pc + 1) % 65536;
    endfunction

    function automatic bit exp_mis();
        return bus.ex_valid && ((bus.ex_pred_taken != bus.ex_taken) ||
                                (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
    endfunction

    function automatic int exp_redirect();
        return bus.ex_taken ? int'(bus.ex_target) : (int'(bus.ex_pc) + 1) % 65536;
    endfunction

    function automatic void model_update();
        int i, t;
        if (exp_mis() && m_cnt < 65535) m_cnt++;
        if (bus.inv) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else if (bus.ex_valid) begin
            i = int'(bus.ex_pc) % 16;
            t = int'(bus.ex_pc) / 16;
            if (m_valid[i] && m_tag[i] == t) begin
                if (bus.ex_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = int'(bus.ex_target);
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (bus.ex_taken) begin
                m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = int'(bus.ex_target); m_ctr[i] = 2;
            end
        end
    endfunction

    task automatic drive(input logic [15:0] ipc, input logic v, input logic [15:0] epc,
                         input logic tk, input logic [15:0] tgt, input logic ptk,
                         input logic [15:0] ptgt, input logic iv);
        bus.if_pc = ipc; bus.ex_valid = v; bus.ex_pc = epc; bus.ex_taken = tk;
        bus.ex_target = tgt; bus.ex_pred_taken = ptk; bus.ex_pred_target = ptgt; bus.inv = iv;
    endtask

    // Advance one edge, update the model with the inputs that edge saw, return at negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(16'h0123, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 16'h0124 || bus.mispred_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_lookup: taken=%0b target=%h cnt=%0d, want 0 0124 0",
                     bus.pred_taken, bus.pred_target, bus.mispred_cnt);
        end
        @(negedge clk);
        pc_reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_train_taken();
        drive(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 16'h0124, 0);
        #1;
        n_vec++;
        if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 16'h0200) begin
            n_err++;
            $display("FAIL train_mispredict: mis=%0b redirect=%h, want 1 0200",
                     bus.mispredict, bus.redirect_pc);
        end
        step();
        drive(16'h0123, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 16'h0200 || bus.mispred_cnt !== 16'd1)
        begin
            n_err++;
            $display("FAIL train_lookup: taken=%0b target=%h cnt=%0d, want 1 0200 1",
                     bus.pred_taken, bus.pred_target, bus.mispred_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            drive(16'h0123, 1, 16'h0123, 0, 16'h0000, 0, 16'h0000, 0);
            step();
        end
        drive(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 16'h0124, 0);
        step();
        drive(16'h0123, 1, 16'h0123, 0, 16'h0000, 0, 16'h0000, 0);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 16'h0124) begin
            n_err++;
            $display("FAIL sat_lookup: taken=%0b target=%h, want 0 0124",
                     bus.pred_taken, bus.pred_target);
        end
        n_vec++;
        if (bus.mispredict !== 1'b0) begin
            n_err++;
            $display("FAIL sat_no_mispredict: mis=%0b, want 0", bus.mispredict);
        end
        step();
    endtask

    task automatic test_alias();
        drive(16'h0133, 1, 16'h0133, 1, 16'h0300, 0, 16'h0134, 0);
        step();
        drive(16'h0133, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 16'h0300) begin
            n_err++;
            $display("FAIL alias_new: taken=%0b target=%h, want 1 0300",
                     bus.pred_taken, bus.pred_target);
        end
        bus.if_pc = 16'h0123;
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 16'h0124) begin
            n_err++;
            $display("FAIL alias_evicted: taken=%0b target=%h, want 0 0124",
                     bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_wrap();
        drive(16'hFFFF, 1, 16'hFFFF, 0, 16'h1234, 1, 16'h1234, 0);
        #1;
        n_vec++;
        if (bus.pred_target !== 16'h0000 || bus.pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_lookup: taken=%0b target=%h, want 0 0000",
                     bus.pred_taken, bus.pred_target);
        end
        n_vec++;
        if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_redirect: mis=%0b redirect=%h, want 1 0000",
                     bus.mispredict, bus.redirect_pc);
        end
        step();
    endtask

    task automatic test_same_cycle();
        // 0x0133 is weakly taken; a not-taken update must not be seen this cycle.
        drive(16'h0133, 1, 16'h0133, 0, 16'h0000, 1, 16'h0300, 0);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 16'h0300) begin
            n_err++;
            $display("FAIL same_cycle_old: taken=%0b target=%h, want 1 0300",
                     bus.pred_taken, bus.pred_target);
        end
        step();
        drive(16'h0133, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 16'h0134) begin
            n_err++;
            $display("FAIL same_cycle_new: taken=%0b target=%h, want 0 0134",
                     bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_inv();
        drive(16'h0123, 1, 16'h0456, 1, 16'h0777, 0, 16'h0457, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] pcs [3];
            pcs[0] = 16'h0133; pcs[1] = 16'h0456; pcs[2] = 16'h0200;
            drive(pcs[k], 0, 0, 0, 0, 0, 0, 0);
            #1;
            n_vec++;
            if (bus.pred_taken !== 1'b0 || bus.pred_target !== pcs[k] + 16'd1) begin
                n_err++;
                $display("FAIL inv_cleared pc=%h: taken=%0b target=%h, want 0 %h",
                         pcs[k], bus.pred_taken, bus.pred_target, pcs[k] + 16'd1);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(16'h0133, 1, 16'h0133, 1, 16'h0999, 0, 16'h0134, 0);
        step();
        drive(16'h0133, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 16'h0999) begin
            n_err++;
            $display("FAIL pre_reset_hit: taken=%0b target=%h, want 1 0999",
                     bus.pred_taken, bus.pred_target);
        end
        #1;
        pc_reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 16'h0134 || bus.mispred_cnt !== 0) begin
            n_err++;
            $display("FAIL async_reset: taken=%0b target=%h cnt=%0d, want 0 0134 0",
                     bus.pred_taken, bus.pred_target, bus.mispred_cnt);
        end
        @(negedge clk);
        pc_reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ipc, epc, tgt, ptgt;
            logic        v, tk, ptk, iv;
            ipc  = {12'($urandom_range(0, 3)), 4'($urandom)};
            epc  = ($urandom_range(0, 15) == 0) ? 16'hFFFF
                                                : {12'($urandom_range(0, 3)), 4'($urandom)};
            if (n % 50 == 7) ipc = 16'hFFFF;
            v    = ($urandom_range(0, 3) != 0);
            tk   = $urandom_range(0, 1) == 1;
            tgt  = ($urandom_range(0, 1) == 1) ? 16'h0A00 : 16'($urandom);
            ptk  = ($urandom_range(0, 3) != 0) ? exp_taken(int'(epc)) : $urandom_range(0, 1) == 1;
            ptgt = ($urandom_range(0, 3) != 0) ? 16'(exp_target(int'(epc))) : 16'h0A00;
            iv   = ($urandom_range(0, 39) == 0);
            drive(ipc, v, epc, tk, tgt, ptk, ptgt, iv);
            #1;
            n_vec++;
            if (bus.pred_taken !== exp_taken(int'(ipc)) ||
                bus.pred_target !== 16'(exp_target(int'(ipc)))) begin
                n_err++;
                $display("FAIL rnd_lookup pc=%h: taken=%0b target=%h, want %0b %h", ipc,
                         bus.pred_taken, bus.pred_target, exp_taken(int'(ipc)),
                         16'(exp_target(int'(ipc))));
            end
            n_vec++;
            if (bus.mispredict !== exp_mis() ||
                (exp_mis() && bus.redirect_pc !== 16'(exp_redirect()))) begin
                n_err++;
                $display("FAIL rnd_resolve: mis=%0b redirect=%h, want %0b %h", bus.mispredict,
                         bus.redirect_pc, exp_mis(), 16'(exp_redirect()));
            end
            n_vec++;
            if (int'(bus.mispred_cnt) != m_cnt) begin
                n_err++;
                $display("FAIL rnd_cnt: cnt=%0d, want %0d", bus.mispred_cnt, m_cnt);
            end
            step();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_train_taken();
        test_saturation();
        test_alias();
        test_wrap();
        test_same_cycle();
        test_inv();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch target buffer with saturating-counter direction prediction for the pipelined CPU family. It is looked up in IF with the fetch PC and supplies a predicted next PC. It is trained in EX with the resolved branch outcome, flags mispredicts and computes the redirect PC. It replaces the always-not-taken, resolve-in-EX-and-flush scheme of the 16-bit core.

## Interface
- ADDR_W, 16: PC / instruction-address width.
- ENTRIES, 16: table entries; power of two, ≥2. IDX_W = log2(ENTRIES), TAG_W = ADDR_W − IDX_W.
- CTR_W, 2: direction counter width, ≥1.

- clk  in  1  sole clock, rising edge.
- pc_reset_n  in  1  reset, asynchronous, active-low.
- if_pc  in  ADDR_W  fetch PC to look up.
- pred_taken  out  1  prediction for if_pc.
- pred_target  out  ADDR_W  predicted next PC.
- ex_valid  in  1  a branch (b/bl/br/beq) is resolved in EX this cycle.
- ex_pc  in  ADDR_W  address of that branch (its own PC, not PC+1).
- ex_taken  in  1  resolved direction.
- ex_target  in  ADDR_W  resolved target.
- ex_pred_taken  in  1  prediction that travelled with the branch down the pipe.
- ex_pred_target  in  ADDR_W  predicted target that travelled with it.
- inv  in  1  synchronous invalidate-all, e.g. after instruction memory reload.
- mispredict  out  1  redirect/flush request.
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1.
- mispred_cnt  out  16  saturating mispredict counter.

## Operation
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[CTR_W]. Index = pc[IDX_W-1:0]. Tag = pc[ADDR_W-1:IDX_W].
- Lookup:
  - hit = valid & tag match.
  - pred_taken = hit & ctr[CTR_W-1].
  - pred_target = (pred_taken) ? entry.target : if_pc+1. The +1 is modulo 2^ADDR_W, so 0xFFFF → 0x0000.
- Mispredict:
  - mispredict = ex_valid & ((ex_pred_taken ≠ ex_taken) | (ex_taken & ex_pred_target ≠ ex_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+1 (same wrap rule). The value is don't-care when mispredict=0.
- Update, at the clock edge when ex_valid=1 and inv=0:
  - Hit at ex_pc: ctr increments when taken, decrements when not taken, saturating at 0 and 2^CTR_W−1. If taken, target ← ex_target, which covers register-indirect br targets that change.
  - Miss and taken: allocate, overwriting whatever is at that index (aliasing evicts). Set valid=1, tag, target=ex_target, ctr=2^(CTR_W−1) (weakly taken).
  - Miss and not taken: no change.
- mispred_cnt increments on every cycle with mispredict=1 and holds at 0xFFFF.
- inv=1 clears every valid bit at the next edge. inv overrides a same-cycle update. ctr, target and mispred_cnt are untouched.
- Reset (asynchronous, immediate, including mid-operation):
  - all valid=0; ctr=2^(CTR_W−1)−1 (weakly not-taken); tags and targets 0; mispred_cnt=0.
  - Consequently pred_taken=0 and pred_target=if_pc+1 while in and after reset.
  - mispredict and redirect_pc follow their inputs combinationally and are not registered.

## Timing
- Lookup is combinational from registered table state: 0-cycle latency, same cycle as if_pc.
- mispredict and redirect_pc are combinational from EX inputs in the same cycle.
- Updates are visible to lookups from the cycle after the edge.
- Same-cycle lookup and update of the same index: the lookup sees the old contents. There is no write-to-read bypass.
- One update port and one lookup port; no back-pressure, no stalls.

## Structure
- Shared package cpu_pkg holds:
  - default ADDR_W
  - a btb_entry_t struct (valid, tag, target, ctr)
  - helper functions ctr_weak_taken(CTR_W) and ctr_weak_not_taken(CTR_W)
- Sub-module sat_counter (parameter W; inputs inc, dec; output next value) is instantiated once on the update path.
- Table is flops, not SRAM, because reset and inv must clear it and lookup is asynchronous.

## Test plan
All scenarios use ADDR_W=16, ENTRIES=16, CTR_W=2.

- **Reset, then lookup 0x0123** → pred_taken=0, pred_target=0x0124, mispred_cnt=0.
- **Train a taken branch:** ex_valid, ex_pc=0x0123, ex_taken=1, ex_target=0x0200, ex_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x0200.
  - Next cycle: lookup 0x0123 gives pred_taken=1, pred_target=0x0200; mispred_cnt=1.
- **Counter saturation:** three not-taken updates at 0x0123 drive ctr 10→01→00→00.
  - One taken update then gives 01, and lookup still gives pred_taken=0.
  - A not-taken update with ex_pred_taken=0 gives mispredict=0.
- **Aliasing:** with 0x0123 allocated, apply a taken update at 0x0133 with target 0x0300 (same index 3).
  - Lookup 0x0133 → 0x0300.
  - Lookup 0x0123 → miss, pred_target=0x0124.
- **Wrap:** lookup 0xFFFF on a miss → pred_target=0x0000. A not-taken mispredict at ex_pc=0xFFFF → redirect_pc=0x0000.
- **Simultaneous events:**
  - Lookup and update of the same index in one cycle → the lookup returns the old prediction.
  - inv together with ex_valid taken → all entries invalid the next cycle.
  - Drop pc_reset_n between edges → all outputs at reset values before the next clk edge.
